// File: rtl/cim_temp_mem_arbiter.sv
// Single-port CiM temp-result storage shared by six requesters; writes beat reads.
// Define CIM_MEM_ARB_RR_EN for round-robin priority within each class (default: fixed, lowest index wins).
module cim_temp_mem_arbiter #(
  parameter int N_SRC  = 6,
  parameter int DEPTH  = 48,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_SRC-1:0]              read_req_src,
  input  logic [N_SRC-1:0]              write_req_src,
  input  logic [N_SRC-1:0][ADDR_W-1:0]  addr_table,
  input  logic [N_SRC-1:0][DATA_W-1:0]  write_data,
  output logic [DATA_W-1:0]             rd_data,
  output logic [N_SRC-1:0]              rd_valid,
  output logic [N_SRC-1:0]              stall,
  output logic                          addr_err,
  input  logic                          clr_err,
  output logic [7:0]                    conflict_cnt
);

  localparam int SRC_W = $clog2(N_SRC);

  // Returns {found, index} of the first set bit scanning upward from start, wrapping.
  function automatic logic [SRC_W:0] pick(input logic [N_SRC-1:0] req,
                                          input logic [SRC_W-1:0] start);
    logic [SRC_W:0]   r;
    logic [SRC_W-1:0] ix;
    r = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      ix = SRC_W'((int'(start) + i) % N_SRC);
      if (req[ix]) r = {1'b1, ix};
    end
    return r;
  endfunction

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [N_SRC-1:0]  rd_valid_q, rd_valid_d;
  logic              addr_err_q, addr_err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [SRC_W-1:0]  start;
  logic [SRC_W:0]    wpick, rpick;
  logic              gnt_vld, gnt_wr, in_range;
  logic [SRC_W-1:0]  gnt_src;
  logic [ADDR_W-1:0] gnt_addr;
  logic [N_SRC-1:0]  gnt_oh, wgnt, rgnt;

`ifdef CIM_MEM_ARB_RR_EN
  logic [SRC_W-1:0] ptr_q, ptr_d;

  assign start = ptr_q;
  assign ptr_d = (gnt_src == SRC_W'(N_SRC - 1)) ? '0 : gnt_src + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr_q <= '0;
    else if (gnt_vld) ptr_q <= ptr_d;
  end
`else
  assign start = '0;
`endif

  always_comb begin
    wpick    = pick(write_req_src, start);
    rpick    = pick(read_req_src, start);
    gnt_wr   = wpick[SRC_W];
    gnt_vld  = wpick[SRC_W] | rpick[SRC_W];
    gnt_src  = gnt_wr ? wpick[SRC_W-1:0] : rpick[SRC_W-1:0];
    gnt_addr = addr_table[gnt_src];
    // Extra bit so a power-of-two DEPTH still compares correctly.
    in_range = ({1'b0, gnt_addr} < (ADDR_W + 1)'(DEPTH));
    gnt_oh   = N_SRC'(1) << gnt_src;
    wgnt     = (gnt_vld && gnt_wr)  ? gnt_oh : '0;
    rgnt     = (gnt_vld && !gnt_wr) ? gnt_oh : '0;
    stall    = (write_req_src & ~wgnt) | (read_req_src & ~rgnt);

    rd_valid_d = rgnt;
    rd_data_d  = rd_data_q;
    if (gnt_vld && !gnt_wr) rd_data_d = in_range ? mem[gnt_addr] : '0;

    addr_err_d = addr_err_q;
    if (clr_err)               addr_err_d = 1'b0;
    if (gnt_vld && !in_range)  addr_err_d = 1'b1;

    cnt_d = cnt_q;
    if ($countones({read_req_src, write_req_src}) > 1 && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (gnt_vld && gnt_wr && in_range) mem[gnt_addr] <= write_data[gnt_src];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      addr_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign addr_err     = addr_err_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_cim_temp_mem_arbiter.sv
// Directed bench for cim_temp_mem_arbiter: RAW, write-over-read priority, fixed/RR arbitration,
// out-of-range handling, conflict counter saturation and mid-operation reset.
module tb_cim_temp_mem_arbiter;

  localparam int N  = 6;
  localparam int AW = 6;
  localparam int DW = 16;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       rd_req, wr_req;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0][DW-1:0] wdata;
  logic [DW-1:0]      rd_data;
  logic [N-1:0]       rd_valid, stall;
  logic               addr_err, clr_err;
  logic [7:0]         conflict_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  cim_temp_mem_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .read_req_src  (rd_req),
    .write_req_src (wr_req),
    .addr_table    (addr),
    .write_data    (wdata),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .stall         (stall),
    .addr_err      (addr_err),
    .clr_err       (clr_err),
    .conflict_cnt  (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0]  exp_stall [3];
  logic [N-1:0]  exp_vld   [3];
  logic [DW-1:0] exp_data  [3];

  initial begin
    rst_n = 1'b0; rd_req = '0; wr_req = '0; clr_err = 1'b0;
    addr = '0; wdata = '0;
    tick(); tick();
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_addr_err", addr_err, 0);
    check_eq("rst_conflict", conflict_cnt, 0);
    check_eq("rst_stall", stall, 0);
    rst_n = 1'b1;
    tick();

    // 1: MAC write then read, same address
    wr_req[3] = 1'b1; addr[3] = 6'd5; wdata[3] = 16'h1234;
    #1 check_eq("t1_wr_stall", stall, 0);
    tick();
    wr_req[3] = 1'b0; rd_req[3] = 1'b1;
    #1 check_eq("t1_wr_no_resp", rd_valid, 0);
    tick();
    rd_req[3] = 1'b0;
    check_eq("t1_rd_valid", rd_valid, 6'b001000);
    check_eq("t1_rd_data", rd_data, 16'h1234);
    tick();
    check_eq("t1_pulse_end", rd_valid, 0);
    check_eq("t1_data_hold", rd_data, 16'h1234);
    check_eq("t1_conflict", conflict_cnt, 0);

    // 2: LOGIC read vs SOFTMAX write
    rd_req[1] = 1'b1; addr[1] = 6'd5;
    wr_req[5] = 1'b1; addr[5] = 6'd7; wdata[5] = 16'hABCD;
    #1 check_eq("t2_stall_first", stall, 6'b000010);
    tick();
    wr_req[5] = 1'b0;
    #1 check_eq("t2_stall_second", stall, 0);
    check_eq("t2_conflict", conflict_cnt, 1);
    tick();
    rd_req[1] = 1'b0;
    check_eq("t2_rd_valid", rd_valid, 6'b000010);
    check_eq("t2_rd_data", rd_data, 16'h1234);
    // SOFTMAX reads back its write; last grant to source 5 leaves any RR pointer at 0
    rd_req[5] = 1'b1;
    tick();
    rd_req[5] = 1'b0;
    check_eq("t2_wb_valid", rd_valid, 6'b100000);
    check_eq("t2_wb_data", rd_data, 16'hABCD);

    // 3: BUS (addr 7) and LAYERNORM (addr 5) hold reads for 3 cycles
`ifdef CIM_MEM_ARB_RR_EN
    exp_stall = '{6'b010000, 6'b000001, 6'b010000};
    exp_vld   = '{6'b000001, 6'b010000, 6'b000001};
    exp_data  = '{16'hABCD, 16'h1234, 16'hABCD};
`else
    exp_stall = '{6'b010000, 6'b010000, 6'b010000};
    exp_vld   = '{6'b000001, 6'b000001, 6'b000001};
    exp_data  = '{16'hABCD, 16'hABCD, 16'hABCD};
`endif
    rd_req[0] = 1'b1; addr[0] = 6'd7;
    rd_req[4] = 1'b1; addr[4] = 6'd5;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq($sformatf("t3_stall_%0d", i), stall, exp_stall[i]);
      tick();
      if (i == 2) begin rd_req[0] = 1'b0; rd_req[4] = 1'b0; end
      check_eq($sformatf("t3_valid_%0d", i), rd_valid, exp_vld[i]);
      check_eq($sformatf("t3_data_%0d", i), rd_data, exp_data[i]);
    end
    check_eq("t3_conflict", conflict_cnt, 4);

    // 4: out-of-range read, clear, and set-beats-clear
    rd_req[2] = 1'b1; addr[2] = 6'd48;
    tick();
    rd_req[2] = 1'b0;
    check_eq("t4_rd_valid", rd_valid, 6'b000100);
    check_eq("t4_rd_data", rd_data, 0);
    check_eq("t4_addr_err", addr_err, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check_eq("t4_cleared", addr_err, 0);
    clr_err = 1'b1; rd_req[2] = 1'b1;
    tick();
    clr_err = 1'b0; rd_req[2] = 1'b0;
    check_eq("t4_set_wins", addr_err, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check_eq("t4_cleared2", addr_err, 0);
    check_eq("t4_conflict", conflict_cnt, 4);

    // 5: two requests every cycle -> saturation
    rd_req[0] = 1'b1; rd_req[1] = 1'b1;
    for (int i = 0; i < 250; i++) tick();
    check_eq("t5_conflict_254", conflict_cnt, 254);
    for (int i = 0; i < 50; i++) tick();
    check_eq("t5_conflict_sat", conflict_cnt, 255);
    rd_req = '0;
    tick();

    // 6: reset right after a read grant
    rd_req[3] = 1'b1;
    tick();
    rd_req[3] = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", rd_valid, 0);
    check_eq("t6_rst_data", rd_data, 0);
    check_eq("t6_rst_conflict", conflict_cnt, 0);
    check_eq("t6_rst_err", addr_err, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_eq("t6_post_valid", rd_valid, 0);
    rd_req[3] = 1'b1;
    tick();
    rd_req[3] = 1'b0;
    check_eq("t6_rd_valid", rd_valid, 6'b001000);
    check_eq("t6_rd_data", rd_data, 16'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
